host_mem_avmm_responder: RTL and testbench

Avalon-MM responder for the split read/write host-memory channel driven by the ASP DMA path; it sits where the host memory sits, as the sink end of that channel. It accepts burst reads and burst writes into a small internal line-addressed scratch RAM. It returns read data in order with fixed pipeline latency and reports per-burst write responses. It is used for DMA loopback bring-up and for simulation benches that run without a host.

---
 rtl/host_mem_avmm_responder_if.sv | 36 +++
 rtl/host_mem_avmm_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_host_mem_avmm_responder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_mem_avmm_responder_if.sv
// host_mem_avmm_responder_if: split read/write Avalon-MM host-memory channel.
// The master modport is the DMA side; the slave modport is the memory/responder side.
interface host_mem_avmm_responder_if #(
    parameter int DATA_W  = 512,
    parameter int ADDR_W  = 48,
    parameter int BURST_W = 7
);
    logic [ADDR_W-1:0]   rd_address;
    logic                rd_read;
    logic [BURST_W-1:0]  rd_burstcount;
    logic                rd_waitrequest;
    logic [DATA_W-1:0]   rd_readdata;
    logic                rd_readdatavalid;

    logic [ADDR_W-1:0]   wr_address;
    logic                wr_write;
    logic [BURST_W-1:0]  wr_burstcount;
    logic [DATA_W-1:0]   wr_writedata;
    logic [DATA_W/8-1:0] wr_byteenable;
    logic                wr_waitrequest;
    logic                wr_writeresponsevalid;

    modport master (
        output rd_address, rd_read, rd_burstcount,
        input  rd_waitrequest, rd_readdata, rd_readdatavalid,
        output wr_address, wr_write, wr_burstcount, wr_writedata, wr_byteenable,
        input  wr_waitrequest, wr_writeresponsevalid
    );

    modport slave (
        input  rd_address, rd_read, rd_burstcount,
        output rd_waitrequest, rd_readdata, rd_readdatavalid,
        input  wr_address, wr_write, wr_burstcount, wr_writedata, wr_byteenable,
        output wr_waitrequest, wr_writeresponsevalid
    );
endinterface

// File: rtl/host_mem_avmm_responder.sv
// host_mem_avmm_responder: Avalon-MM sink for the split read/write host-memory
// channel, backed by a small line-addressed scratch RAM. Reads are queued in a
// request FIFO and returned in order through a two-stage pipeline; writes are
// applied per byte lane with one response pulse per burst.
// Optional feature: define HOST_MEM_RESP_RAND_STALL_EN to add LFSR-driven
// random waitrequest stalls on both channels.
module host_mem_avmm_responder #(
    parameter int DATA_W         = 512,
    parameter int ADDR_W         = 48,
    parameter int BURST_W        = 7,
    parameter int MEM_LINES_LOG2 = 6,
    parameter int RD_REQ_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    host_mem_avmm_responder_if.slave bus,
    output logic [31:0]              rd_beats,
    output logic [31:0]              wr_bursts,
    output logic                     err_burst0
);
    localparam int IDX_W = MEM_LINES_LOG2;
    localparam int LINES = 1 << IDX_W;
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (RD_REQ_DEPTH > 1) ? $clog2(RD_REQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [BURST_W-1:0] ONE_B = BURST_W'(1);
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(RD_REQ_DEPTH);

    // Only the RAM index survives into the FIFO; burst length is stored already
    // normalised (0 -> 1) so the read engine never sees a zero count.
    typedef struct packed {
        logic [IDX_W-1:0]   idx;
        logic [BURST_W-1:0] len;
    } rd_req_t;

    typedef enum logic {RD_IDLE, RD_BURST} rd_state_e;
    typedef enum logic {WR_IDLE, WR_BURST} wr_state_e;

    logic rd_stall, wr_stall;

`ifdef HOST_MEM_RESP_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    // Fibonacci LFSR x^16+x^14+x^13+x^11, free running
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // LFSR state register, reseeded on reset
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
    assign rd_stall = (lfsr_q[1:0] == 2'b00);
    assign wr_stall = (lfsr_q[3:2] == 2'b00);
`else
    assign rd_stall = 1'b0;
    assign wr_stall = 1'b0;
`endif

    // Scratch RAM and request FIFO storage (not reset)
    logic [DATA_W-1:0] mem_q [LINES];
    rd_req_t           fifo_q [RD_REQ_DEPTH];

    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    rd_state_e         rd_state_q, rd_state_d;
    logic [IDX_W-1:0]  raddr_q, raddr_d;
    logic [BURST_W-1:0] rrem_q, rrem_d;
    wr_state_e         wr_state_q, wr_state_d;
    logic [IDX_W-1:0]  waddr_q, waddr_d;
    logic [BURST_W-1:0] wrem_q, wrem_d;
    logic [1:0]        vld_pipe_q, vld_pipe_d;
    logic [DATA_W-1:0] ram_rdata_q, ram_rdata_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              resp_q, resp_d;
    logic [31:0]       rd_beats_q, rd_beats_d;
    logic [31:0]       wr_bursts_q, wr_bursts_d;
    logic              err_q, err_d;

    logic              fifo_full, fifo_empty, rd_push, rd_pop, rd_issue;
    logic              wr_acc, wr_done;
    logic [IDX_W-1:0]  rd_idx, wr_idx;
    rd_req_t           rd_req_in, fifo_head;
    logic [BURST_W-1:0] wr_len_in;

    assign fifo_full  = (cnt_q == DEPTH_C);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_head  = fifo_q[rptr_q];

    // Waitrequest is high through reset; full-and-popping still stalls this cycle.
    assign bus.rd_waitrequest = reset | fifo_full | rd_stall;
    assign bus.wr_waitrequest = reset | wr_stall;

    assign rd_push = bus.rd_read  && !bus.rd_waitrequest;
    assign wr_acc  = bus.wr_write && !bus.wr_waitrequest;

    assign rd_req_in.idx = bus.rd_address[IDX_W-1:0];
    assign rd_req_in.len = (bus.rd_burstcount == '0) ? ONE_B : bus.rd_burstcount;
    assign wr_len_in     = (bus.wr_burstcount == '0) ? ONE_B : bus.wr_burstcount;

    // Upper address bits alias by design
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.rd_address[ADDR_W-1:IDX_W], bus.wr_address[ADDR_W-1:IDX_W]};

    // Read engine: the idle state pops and issues beat 0 in the same cycle so the
    // first beat lands three cycles after acceptance; last beat chains the next request.
    always_comb begin
        rd_state_d = rd_state_q;
        raddr_d    = raddr_q;
        rrem_d     = rrem_q;
        rd_pop     = 1'b0;
        rd_issue   = 1'b0;
        rd_idx     = raddr_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (!fifo_empty) begin
                    rd_pop   = 1'b1;
                    rd_issue = 1'b1;
                    rd_idx   = fifo_head.idx;
                    raddr_d  = fifo_head.idx + 1'b1;
                    rrem_d   = fifo_head.len - 1'b1;
                    if (fifo_head.len != ONE_B) rd_state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                rd_issue = 1'b1;
                if (rrem_q == ONE_B) begin
                    if (!fifo_empty) begin
                        rd_pop  = 1'b1;
                        raddr_d = fifo_head.idx;
                        rrem_d  = fifo_head.len;
                    end else begin
                        rd_state_d = RD_IDLE;
                    end
                end else begin
                    raddr_d = raddr_q + 1'b1;
                    rrem_d  = rrem_q - 1'b1;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Write engine: first beat latches address/length, each beat writes the next line
    always_comb begin
        wr_state_d = wr_state_q;
        waddr_d    = waddr_q;
        wrem_d     = wrem_q;
        wr_idx     = waddr_q;
        wr_done    = 1'b0;
        if (wr_acc) begin
            case (wr_state_q)
                WR_IDLE: begin
                    wr_idx  = bus.wr_address[IDX_W-1:0];
                    waddr_d = bus.wr_address[IDX_W-1:0] + 1'b1;
                    wrem_d  = wr_len_in - 1'b1;
                    if (wr_len_in == ONE_B) wr_done = 1'b1;
                    else                    wr_state_d = WR_BURST;
                end
                WR_BURST: begin
                    waddr_d = waddr_q + 1'b1;
                    wrem_d  = wrem_q - 1'b1;
                    if (wrem_q == ONE_B) begin
                        wr_done    = 1'b1;
                        wr_state_d = WR_IDLE;
                    end
                end
                default: wr_state_d = WR_IDLE;
            endcase
        end
    end

    // FIFO pointers, read return pipeline, counters and sticky error
    always_comb begin
        wptr_d      = wptr_q + PTR_W'(rd_push);
        rptr_d      = rptr_q + PTR_W'(rd_pop);
        cnt_d       = cnt_q + CNT_W'(rd_push) - CNT_W'(rd_pop);
        ram_rdata_d = mem_q[rd_idx];
        vld_pipe_d  = {vld_pipe_q[0], rd_issue};
        out_data_d  = vld_pipe_q[0] ? ram_rdata_q : out_data_q;
        rd_beats_d  = rd_beats_q + 32'(vld_pipe_q[0]);
        resp_d      = wr_done;
        wr_bursts_d = wr_bursts_q + 32'(wr_done);
        err_d       = err_q
                    | (rd_push && bus.rd_burstcount == '0)
                    | (wr_acc && wr_state_q == WR_IDLE && bus.wr_burstcount == '0);
    end

    // Control state; reset flushes the FIFO and drops in-flight beats
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            rd_state_q  <= RD_IDLE;
            raddr_q     <= '0;
            rrem_q      <= '0;
            wr_state_q  <= WR_IDLE;
            waddr_q     <= '0;
            wrem_q      <= '0;
            vld_pipe_q  <= '0;
            out_data_q  <= '0;
            resp_q      <= 1'b0;
            rd_beats_q  <= '0;
            wr_bursts_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            rd_state_q  <= rd_state_d;
            raddr_q     <= raddr_d;
            rrem_q      <= rrem_d;
            wr_state_q  <= wr_state_d;
            waddr_q     <= waddr_d;
            wrem_q      <= wrem_d;
            vld_pipe_q  <= vld_pipe_d;
            out_data_q  <= out_data_d;
            resp_q      <= resp_d;
            rd_beats_q  <= rd_beats_d;
            wr_bursts_q <= wr_bursts_d;
            err_q       <= err_d;
        end
    end

    // Storage: FIFO entries, byte-lane RAM writes, registered RAM read (old data on collision)
    always_ff @(posedge clk) begin
        if (rd_push) fifo_q[wptr_q] <= rd_req_in;
        if (wr_acc) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.wr_byteenable[b]) mem_q[wr_idx][b*8 +: 8] <= bus.wr_writedata[b*8 +: 8];
            end
        end
        if (rd_issue) ram_rdata_q <= ram_rdata_d;
    end

    assign bus.rd_readdata           = out_data_q;
    assign bus.rd_readdatavalid      = vld_pipe_q[1];
    assign bus.wr_writeresponsevalid = resp_q;
    assign rd_beats                  = rd_beats_q;
    assign wr_bursts                 = wr_bursts_q;
    assign err_burst0                = err_q;
endmodule

// File: tb/tb_host_mem_avmm_responder.sv
// tb_host_mem_avmm_responder: directed and randomized bench for the host-memory
// responder. A line-array model tracks RAM contents; every accepted read pushes
// its expected beats, and a negedge monitor compares returned beats in order.
module tb_host_mem_avmm_responder;
    localparam int DATA_W  = 512;
    localparam int ADDR_W  = 48;
    localparam int BURST_W = 7;
    localparam int LINES   = 64;
    localparam int BE_W    = DATA_W / 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rd_beats, wr_bursts;
    logic        err_burst0;

    host_mem_avmm_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

    host_mem_avmm_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W),
        .MEM_LINES_LOG2(6), .RD_REQ_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .rd_beats(rd_beats), .wr_bursts(wr_bursts), .err_burst0(err_burst0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] mem_m [LINES];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] wd_q [$];
    logic [BE_W-1:0]   wbe_q [$];
    int vcyc [$];
    int vectors = 0, miscompares = 0;
    int exp_rd_total = 0, exp_wr = 0, n_resp = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_line();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void model_wr(input int idx, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        for (int b = 0; b < BE_W; b++) if (be[b]) mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    // Returned-beat monitor: in-order data against the model, valid-cycle log, response count
    always @(negedge clk) begin
        if (bus.rd_readdatavalid === 1'b1) begin
            vcyc.push_back(cyc);
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL rd_unexpected_beat: observed data %0h expected no beat", bus.rd_readdata);
            end
            if (exp_q.size() != 0) chk("rd_data", bus.rd_readdata, exp_q.pop_front());
        end
        if (bus.wr_writeresponsevalid === 1'b1) n_resp++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_issue(input logic [ADDR_W-1:0] a, input int bc, output int t_acc, output int waited);
        int n, base;
        bus.rd_read = 1'b1;
        bus.rd_address = a;
        bus.rd_burstcount = BURST_W'(bc);
        waited = 0;
        while (bus.rd_waitrequest !== 1'b0 && waited < 400) begin
            tick();
            waited++;
        end
        chk("rd_accept_timeout", DATA_W'(waited < 400), DATA_W'(1));
        t_acc = cyc;
        n = (bc == 0) ? 1 : bc;
        base = int'(a[5:0]);
        for (int k = 0; k < n; k++) exp_q.push_back(mem_m[(base + k) % LINES]);
        exp_rd_total += n;
        tick();
        bus.rd_read = 1'b0;
    endtask

    task automatic fill(input int n, input bit rnd_be);
        for (int k = 0; k < n; k++) begin
            wd_q.push_back(rnd_line());
            wbe_q.push_back(rnd_be ? {$urandom, $urandom} : {BE_W{1'b1}});
        end
    endtask

    // Drives one complete write burst from wd_q/wbe_q and checks the response timing
    task automatic wr_burst(input logic [ADDR_W-1:0] a, input int bc);
        int n, base, w;
        logic [DATA_W-1:0] d;
        logic [BE_W-1:0] be;
        n = (bc == 0) ? 1 : bc;
        base = int'(a[5:0]);
        for (int k = 0; k < n; k++) begin
            d = wd_q.pop_front();
            be = wbe_q.pop_front();
            bus.wr_write = 1'b1;
            bus.wr_address = a;
            bus.wr_burstcount = BURST_W'(bc);
            bus.wr_writedata = d;
            bus.wr_byteenable = be;
            w = 0;
            while (bus.wr_waitrequest !== 1'b0 && w < 400) begin
                tick();
                w++;
            end
            if (w >= 400) chk("wr_accept_timeout", DATA_W'(w), DATA_W'(0));
            model_wr((base + k) % LINES, d, be);
            tick();
        end
        bus.wr_write = 1'b0;
        exp_wr++;
        @(negedge clk);
        chk("wr_resp_pulse", DATA_W'(bus.wr_writeresponsevalid), DATA_W'(1));
        chk("wr_bursts", DATA_W'(wr_bursts), DATA_W'(exp_wr));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        chk("rd_drain", DATA_W'(exp_q.size()), DATA_W'(0));
        exp_q.delete();
        repeat (3) tick();
    endtask

    initial begin
        int t, w, gaps, snap;
        bus.rd_read = 1'b0; bus.rd_address = '0; bus.rd_burstcount = '0;
        bus.wr_write = 1'b0; bus.wr_address = '0; bus.wr_burstcount = '0;
        bus.wr_writedata = '0; bus.wr_byteenable = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_rd_wait", DATA_W'(bus.rd_waitrequest), DATA_W'(1));
        chk("rst_wr_wait", DATA_W'(bus.wr_waitrequest), DATA_W'(1));
        chk("rst_rd_valid", DATA_W'(bus.rd_readdatavalid), DATA_W'(0));
        chk("rst_wr_resp", DATA_W'(bus.wr_writeresponsevalid), DATA_W'(0));
        chk("rst_rd_data", bus.rd_readdata, '0);
        chk("rst_rd_beats", DATA_W'(rd_beats), DATA_W'(0));
        chk("rst_wr_bursts", DATA_W'(wr_bursts), DATA_W'(0));
        chk("rst_err", DATA_W'(err_burst0), DATA_W'(0));
        reset = 1'b0;
        tick();
        chk("post_rst_rd_wait", DATA_W'(bus.rd_waitrequest), DATA_W'(0));
        chk("post_rst_wr_wait", DATA_W'(bus.wr_waitrequest), DATA_W'(0));

        // Initialise every line with a 64-beat burst
        fill(64, 1'b0);
        wr_burst(48'h0, 64);

        // Burst of 4 at 0x10 with 0xA0..0xA3, then read back with latency check
        for (int k = 0; k < 4; k++) begin
            wd_q.push_back(DATA_W'(8'hA0 + k));
            wbe_q.push_back({BE_W{1'b1}});
        end
        wr_burst(48'h10, 4);
        vcyc.delete();
        rd_issue(48'h10, 4, t, w);
        drain();
        chk("lat_nbeats", DATA_W'(vcyc.size()), DATA_W'(4));
        for (int k = 0; k < 4 && k < vcyc.size(); k++)
            chk($sformatf("lat_beat%0d", k), DATA_W'(vcyc[k]), DATA_W'(t + 3 + k));
        chk("rd_beats_4", DATA_W'(rd_beats), DATA_W'(exp_rd_total));

        // Byte-lane merge at 0x3F and alias through 0x7F
        wd_q.push_back('0); wbe_q.push_back({BE_W{1'b1}});
        wr_burst(48'h3F, 1);
        wd_q.push_back({DATA_W{1'b1}}); wbe_q.push_back(BE_W'(1));
        wr_burst(48'h3F, 1);
        rd_issue(48'h3F, 1, t, w);
        rd_issue(48'h7F, 1, t, w);
        drain();

        // FIFO backpressure behind a 64-beat burst; returns must be gap-free
        vcyc.delete();
        rd_issue(48'h0, 64, t, w);
        for (int k = 0; k < 4; k++) begin
            rd_issue(48'(k + 8), 1, t, w);
            chk($sformatf("fifo_nowait%0d", k), DATA_W'(w), DATA_W'(0));
        end
        rd_issue(48'h20, 1, t, w);
        chk("fifo_full_wait", DATA_W'(w > 0), DATA_W'(1));
        drain();
        gaps = 0;
        for (int k = 1; k < vcyc.size(); k++) if (vcyc[k] != vcyc[k-1] + 1) gaps++;
        chk("gapfree_gaps", DATA_W'(gaps), DATA_W'(0));
        chk("gapfree_nbeats", DATA_W'(vcyc.size()), DATA_W'(69));

        // Address wrap and burstcount 0
        rd_issue(48'h3F, 2, t, w);
        drain();
        chk("err_before_bc0", DATA_W'(err_burst0), DATA_W'(0));
        vcyc.delete();
        rd_issue(48'h5, 0, t, w);
        drain();
        chk("bc0_nbeats", DATA_W'(vcyc.size()), DATA_W'(1));
        chk("err_bc0", DATA_W'(err_burst0), DATA_W'(1));

        // Randomized write/read mix
        for (int it = 0; it < 25; it++) begin
            int bc;
            bc = $urandom_range(0, 8);
            fill((bc == 0) ? 1 : bc, 1'b1);
            wr_burst({$urandom, $urandom}, bc);
            for (int r = 0; r < 3; r++) rd_issue({$urandom, $urandom}, $urandom_range(0, 8), t, w);
            drain();
        end
        chk("tot_rd_beats", DATA_W'(rd_beats), DATA_W'(exp_rd_total));
        chk("tot_wr_bursts", DATA_W'(wr_bursts), DATA_W'(exp_wr));
        chk("tot_resp", DATA_W'(n_resp), DATA_W'(exp_wr));
        chk("err_sticky", DATA_W'(err_burst0), DATA_W'(1));

        // Reset on the 3rd beat of an 8-beat write: no response, counters cleared
        snap = n_resp;
        bus.wr_write = 1'b1; bus.wr_address = 48'h20; bus.wr_burstcount = 7'd8;
        bus.wr_byteenable = {BE_W{1'b1}};
        for (int k = 0; k < 2; k++) begin
            bus.wr_writedata = rnd_line();
            model_wr(32 + k, bus.wr_writedata, {BE_W{1'b1}});
            tick();
        end
        bus.wr_writedata = rnd_line();
        reset = 1'b1;
        tick();
        chk("midrst_wr_wait", DATA_W'(bus.wr_waitrequest), DATA_W'(1));
        bus.wr_write = 1'b0;
        tick();
        reset = 1'b0;
        exp_wr = 0; exp_rd_total = 0;
        repeat (3) tick();
        chk("midrst_no_resp", DATA_W'(n_resp), DATA_W'(snap));
        chk("midrst_wr_bursts", DATA_W'(wr_bursts), DATA_W'(0));
        chk("midrst_rd_beats", DATA_W'(rd_beats), DATA_W'(0));
        chk("midrst_err", DATA_W'(err_burst0), DATA_W'(0));
        fill(1, 1'b0);
        wr_burst(48'h5, 1);
        rd_issue(48'h20, 3, t, w);
        drain();
        chk("final_rd_beats", DATA_W'(rd_beats), DATA_W'(3));
        chk("final_resp", DATA_W'(n_resp - snap), DATA_W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end
endmodule
